// File: rtl/dmem_tport_reader.sv
// -----------------------------------------------------------------------------
// dmem_tport_reader
//
// Read-side engine for the data memory's secondary (t) port. A start command
// latches a word-aligned base address and a word count. The engine then reads
// the block one 32-bit word at a time through the t port and emits each word
// as four bytes, MSB first, over a valid/ready byte stream. The t port is only
// ever read: te and td are tied low.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      command strobe, honoured only while idle
//   base_addr  in   32     byte address of the first word (bits [1:0] dropped)
//   word_cnt   in   CNT_W  number of words to stream (0 = immediate done)
//   ta         out  32     t-port byte address (always the current word addr)
//   te         out  1      t-port write enable, constant 0
//   td         out  32     t-port write data, constant 0
//   rtd        in   32     t-port read data, combinational from ta
//   out_data   out  8      stream byte (0 when not valid)
//   out_valid  out  1      stream byte valid
//   out_ready  in   1      sink accepts the byte
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse at the end of a command
//
// Cycle budget with out_ready held high: one FETCH cycle plus four SEND cycles
// per word, then one DONE cycle, i.e. 5*W+1 busy cycles.
// -----------------------------------------------------------------------------
module dmem_tport_reader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic [31:0]      ta,
  output logic             te,
  output logic [31:0]      td,
  input  logic [31:0]      rtd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       byte_idx_q, byte_idx_d;

  logic             xfer;

  // A byte leaves only while SEND presents it and the sink takes it.
  assign xfer = (state_q == S_SEND) && out_ready;

  // ---------------------------------------------------------------------------
  // State and datapath registers. Every register is cleared by reset so that
  // an aborted command leaves nothing behind that could leak into the next.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      rem_q      <= '0;
      shift_q    <= 32'd0;
      byte_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            // Masking keeps every base_addr bit in the cone while forcing
            // word alignment.
            addr_d  = base_addr & 32'hFFFF_FFFC;
            rem_d   = word_cnt;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        // rtd is the combinational read of ta (= addr_q) in this cycle.
        shift_d    = rtd;
        byte_idx_d = 2'd0;
        addr_d     = addr_q + 32'd4;   // wraps naturally at 2^32
        rem_d      = rem_q - CNT_W'(1);
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (xfer) begin
          shift_d    = {shift_q[23:0], 8'd0};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // rem_q was already decremented when this word was fetched.
            state_d = (rem_q != '0) ? S_FETCH : S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded straight from the registered state, so reset clears them
  // in the same delta as the registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'd0;
    if (state_q == S_SEND) begin
      out_valid = 1'b1;
      out_data  = shift_q[31:24];
    end
  end

  assign ta   = addr_q;
  assign te   = 1'b0;
  assign td   = 32'd0;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_tport_reader.sv
module tb_dmem_tport_reader;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0]      ta;
  logic             te;
  logic [31:0]      td;
  logic [31:0]      rtd;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  // 16-word memory image, aliased on ta[5:2].
  logic [31:0] mem [16];
  assign rtd = mem[ta[5:2]];

  int n_total;
  int n_bad;

  dmem_tport_reader #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .ta        (ta),
    .te        (te),
    .td        (td),
    .rtd       (rtd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic [31:0]      base;
    logic [31:0]      ta0;       // expected first fetch address
    int               cnt;
    bit               bp;        // out_ready toggles 1,0,1,0...
    int               poke;      // cycle at which a stray start is pulsed (0 = none)
    int               done_cyc;  // expected done cycle after start edge (-1 = skip)
    logic [2:0][31:0] w;         // memory words, w[0] first
  } vec_t;

  vec_t vec [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input bit at_neg);
    int  nbytes;
    int  nfetch;
    bit  stalled;
    bit  seen_done;
    logic [7:0] prev_data;
    logic [7:0] exp_b;
    logic [31:0] wd;
    for (int i = 0; i < v.cnt; i++) mem[((v.base >> 2) + i) & 15] = v.w[i];
    if (!at_neg) @(negedge clk);
    start     = 1'b1;
    base_addr = v.base;
    word_cnt  = CNT_W'(v.cnt);
    out_ready = 1'b1;
    @(posedge clk);
    nbytes = 0; nfetch = 0; stalled = 0; seen_done = 0; prev_data = 8'd0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start     = (k == v.poke);
      base_addr = 32'h0000_0040;
      word_cnt  = CNT_W'(5);
      if (stalled) begin
        chk({v.name, " hold_valid"}, {31'd0, out_valid}, 32'd1);
        chk({v.name, " hold_data"}, {24'd0, out_data}, {24'd0, prev_data});
      end
      if (busy && !out_valid && !done) begin
        chk({v.name, " ta"}, ta, v.ta0 + 32'(4 * nfetch));
        nfetch++;
      end
      out_ready = v.bp ? k[0] : 1'b1;
      if (out_valid) begin
        if (nbytes < 4 * v.cnt) begin
          wd    = v.w[nbytes / 4];
          exp_b = wd[31 - 8 * (nbytes % 4) -: 8];
          chk({v.name, " byte"}, {24'd0, out_data}, {24'd0, exp_b});
        end else begin
          chk({v.name, " extra_byte"}, {24'd0, out_data}, 32'hFFFF_FFFF);
        end
        if (out_ready) nbytes++;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        seen_done = 1;
        if (v.done_cyc > 0) chk({v.name, " done_cycle"}, k, v.done_cyc);
        break;
      end
    end
    start = 1'b0;
    chk({v.name, " done_seen"}, {31'd0, seen_done}, 32'd1);
    chk({v.name, " nbytes"}, nbytes, 4 * v.cnt);
    chk({v.name, " nfetch"}, nfetch, v.cnt);
    @(negedge clk);
    chk({v.name, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({v.name, " idle_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hEEEE_0000 | i;

    vec[0] = '{"single", 32'h0000_0010, 32'h0000_0010, 1, 1'b0, 0, 6,
               {32'h0, 32'h0, 32'hA1B2C3D4}};
    vec[1] = '{"multi_bp", 32'h0000_0013, 32'h0000_0010, 3, 1'b1, 0, -1,
               {32'h090A0B0C, 32'h05060708, 32'h01020304}};
    vec[2] = '{"wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 1'b0, 0, 11,
               {32'h0, 32'h12345678, 32'hDEADBEEF}};
    vec[3] = '{"ignored_start", 32'h0000_0020, 32'h0000_0020, 2, 1'b0, 4, 11,
               {32'h0, 32'h87654321, 32'h55AA6699}};
    vec[4] = '{"three_full", 32'h0000_0030, 32'h0000_0030, 3, 1'b0, 0, 16,
               {32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3}};

    // Reset
    rst_n = 1'b0; start = 1'b0; base_addr = 32'h1234_5677; word_cnt = CNT_W'(3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst data", {24'd0, out_data}, 32'd0);
    chk("rst ta", ta, 32'd0);
    chk("rst te", {31'd0, te}, 32'd0);
    chk("rst td", td, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst busy", {31'd0, busy}, 32'd0);
    chk("post_rst done", {31'd0, done}, 32'd0);

    // Table-driven jobs; from the second one on, start lands in the first
    // IDLE cycle after DONE.
    for (int i = 0; i < 5; i++) run_job(vec[i], i != 0);

    // Zero count
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_0008; word_cnt = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero busy", {31'd0, busy}, 32'd1);
    chk("zero done", {31'd0, done}, 32'd1);
    chk("zero valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("zero busy2", {31'd0, busy}, 32'd0);
    chk("zero done2", {31'd0, done}, 32'd0);
    chk("zero valid2", {31'd0, out_valid}, 32'd0);

    // Reset mid-transfer after the second byte
    mem[4] = 32'h11223344; mem[5] = 32'h55667788;
    start = 1'b1; base_addr = 32'h0000_0010; word_cnt = CNT_W'(2); out_ready = 1'b1;
    @(negedge clk);          // cycle 1: FETCH
    start = 1'b0;
    chk("mid ta", ta, 32'h0000_0010);
    @(negedge clk);          // cycle 2: byte 0x11
    chk("mid b0", {24'd0, out_data}, 32'h11);
    @(negedge clk);          // cycle 3: byte 0x22
    chk("mid b1", {24'd0, out_data}, 32'h22);
    @(negedge clk);          // cycle 4: byte 0x33 pending
    chk("mid b2", {24'd0, out_data}, 32'h33);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst done", {31'd0, done}, 32'd0);
    chk("mid rst data", {24'd0, out_data}, 32'd0);
    chk("mid rst ta", ta, 32'd0);
    @(negedge clk);
    chk("mid hold done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid after busy", {31'd0, busy}, 32'd0);
    chk("mid after done", {31'd0, done}, 32'd0);
    run_job('{"after_reset", 32'h0000_0024, 32'h0000_0024, 1, 1'b0, 0, 6,
              {32'h0, 32'h0, 32'hCAFEF00D}}, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_tport_reader.md
# dmem_tport_reader

Read-side engine for the data memory's secondary (t) port. On a start command it reads a block of consecutive 32-bit words from data memory and emits them as a byte stream over a valid/ready handshake, for example to a UART transmitter or debug dump path. It sits between data memory (`ta`, `rtd`, `te`) and any byte-wide sink, and it never writes memory.

## Interface
- `CNT_W`, default 16: width of the word-count input; the maximum block is 2^CNT_W − 1 words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle command strobe. Sampled only in IDLE.
- `base_addr`  in  32  byte address of the first word. Bits [1:0] are ignored and forced to 0.
- `word_cnt`  in  CNT_W  number of words to stream.
- `ta`  out  32  data-memory t-port byte address, word-aligned.
- `te`  out  1  data-memory t-port write enable. Tied to 0.
- `td`  out  32  data-memory t-port write data. Tied to 0.
- `rtd`  in  32  data-memory t-port read data. This is a combinational read of the word at `ta`, valid in the same cycle.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte. A transfer happens on a rising edge where `out_valid` and `out_ready` are both 1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final byte transfers, or after a zero-count start.

## Operation
- **States:** IDLE, FETCH, SEND, DONE.
- **IDLE:**
  - `start`=1 with `word_cnt`≠0 → FETCH. Latch `addr_q`={base_addr[31:2],2'b00} and `rem_q`=`word_cnt`.
  - `start`=1 with `word_cnt`=0 → DONE.
- **FETCH:**
  - `ta`=`addr_q`.
  - On the edge, capture `shift_q`=`rtd`, set `byte_idx`=0, then:
    - `addr_q` += 4, modulo 2^32 (wraps 0xFFFFFFFC → 0x00000000);
    - `rem_q` −= 1;
    - go to SEND.
- **SEND:**
  - `out_valid`=1 and `out_data`=`shift_q`[31:24]; bytes go out MSB first.
  - On each transfer, shift `shift_q` left by 8 and increment `byte_idx`.
  - On the transfer where `byte_idx`=3:
    - if `rem_q`≠0 → FETCH;
    - if `rem_q`=0 → DONE.
  - While `out_ready`=0, `out_data` and `out_valid` are held stable.
- **DONE:** `done`=1 for exactly one cycle, then → IDLE.
- **Outputs outside SEND:** `out_valid`=0 and `out_data`=0.
- **`ta` outside FETCH:** `ta` holds `addr_q`.
- **`start` while busy:** ignored. It is neither queued nor allowed to alter the transfer in progress.
- **Inputs at start:** `base_addr` and `word_cnt` are sampled only on the accepted `start` edge. Later changes have no effect.
- **Reset:** `rst_n` low at any time, including mid-transfer, forces the following within the same delta (asynchronously):
  - state=IDLE, `busy`=0, `done`=0;
  - `out_valid`=0, `out_data`=0;
  - `ta`=0, `addr_q`=0, `rem_q`=0, `shift_q`=0, `byte_idx`=0.
  
  The aborted transfer is not resumed.
- `te`=0 and `td`=0 always.

## Timing
- **Reset values:** every output is 0.
- **Start latency:** `start` sampled at edge N puts the FSM in FETCH during cycle N+1. `out_valid` rises in cycle N+2.
- **Byte rate:** with `out_ready` held 1, one byte transfers per cycle.
- **Between words:** there is exactly one bubble cycle (FETCH, `out_valid`=0).
- **Total time:** for W words with `out_ready`=1, `done` pulses 5W+1 cycles after the start edge, and `busy` is high for 5W+1 cycles.
- **Zero count:** `start` with `word_cnt`=0 gives `busy`=1 and `done`=1 in cycle N+1, and `out_valid` never rises.
- **Back-to-back commands:** a new `start` is accepted in the IDLE cycle that follows DONE, at the earliest.

## Test plan
- **Reset:** hold `rst_n`=0, then release → all outputs 0, state IDLE, no `done`.
- **Single word:**
  - Stimulus: memory[0x10]=0xA1B2C3D4; `start` with base=0x10, cnt=1, `out_ready`=1.
  - Expected: `ta`=0x10 in the FETCH cycle; bytes A1, B2, C3, D4 on consecutive cycles; `done` pulse at cycle 6.
- **Multi-word with backpressure:**
  - Stimulus: base=0x13 (aligned to 0x10), cnt=3, memory 0x10/0x14/0x18 = 0x01020304/0x05060708/0x090A0B0C; `out_ready` toggling 1,0,1,0….
  - Expected: 12 bytes 01..0C in order; `out_data` stable while stalled; `ta` sequence 0x10, 0x14, 0x18.
- **Address wrap:**
  - Stimulus: base=0xFFFFFFFC, cnt=2.
  - Expected: `ta`=0xFFFFFFFC then 0x00000000; 8 bytes streamed.
- **Zero count and ignored start:**
  - Stimulus: cnt=0, then a second `start` pulsed while a cnt=2 job is busy.
  - Expected: `done` one cycle after the zero-count start with no `out_valid`; the busy job still emits exactly 8 bytes.
- **Reset mid-transfer:**
  - Stimulus: drop `rst_n` after the 2nd byte of a cnt=2 job.
  - Expected: `out_valid` and `busy` go to 0 immediately with no `done`; a new cnt=1 job after release streams correctly.
